// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the ALU control and the multiply/divide unit.
// MULTDIV_MTHILO_EN adds the MTHI/MTLO write port.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             iStartMult;
    logic             iStartDiv;
    logic             iSigned;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic             oDivByZero;
    logic [WIDTH-1:0] oHI;
    logic [WIDTH-1:0] oLO;
`ifdef MULTDIV_MTHILO_EN
    logic             iWrHI;
    logic             iWrLO;
    logic [WIDTH-1:0] iWrData;

    modport master (
        output iStartMult, iStartDiv, iSigned, iA, iB, iWrHI, iWrLO, iWrData,
        input  oBusy, oDone, oDivByZero, oHI, oLO
    );
    modport slave (
        input  iStartMult, iStartDiv, iSigned, iA, iB, iWrHI, iWrLO, iWrData,
        output oBusy, oDone, oDivByZero, oHI, oLO
    );
`else
    modport master (
        output iStartMult, iStartDiv, iSigned, iA, iB,
        input  oBusy, oDone, oDivByZero, oHI, oLO
    );
    modport slave (
        input  iStartMult, iStartDiv, iSigned, iA, iB,
        output oBusy, oDone, oDivByZero, oHI, oLO
    );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, WIDTH+2 cycles busy.
// Optional MTHI/MTLO write port enabled by MULTDIV_MTHILO_EN.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    mult_div_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNTW-1:0]    cnt;
    logic               is_mult, dbz, q_neg, r_neg;
    logic [WIDTH-1:0]   dvs, raw_a, hi, lo;
    logic [2*WIDTH-1:0] acc;

    logic             start, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign start = bus.iStartMult | bus.iStartDiv;
    assign a_neg = bus.iSigned & bus.iA[WIDTH-1];
    assign b_neg = bus.iSigned & bus.iB[WIDTH-1];
    assign a_mag = a_neg ? -bus.iA : bus.iA;
    assign b_mag = b_neg ? -bus.iB : bus.iB;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
        mul_step  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvs};
        div_ge    = div_shift >= {1'b0, dvs};
        div_step  = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        prod      = q_neg ? -acc : acc;
        quo       = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem       = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cnt     <= '0;
            is_mult <= 1'b0;
            dbz     <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dvs     <= '0;
            raw_a   <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Multiply has priority when both strobes arrive together.
                        is_mult <= bus.iStartMult;
                        dbz     <= !bus.iStartMult && (bus.iB == '0);
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        dvs     <= b_mag;
                        raw_a   <= bus.iA;
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        cnt     <= CNTW'(WIDTH - 1);
                    end
`ifdef MULTDIV_MTHILO_EN
                    if (bus.iWrHI) hi <= bus.iWrData;
                    if (bus.iWrLO) lo <= bus.iWrData;
`endif
                end
                RUN: begin
                    acc <= is_mult ? mul_step : div_step;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (is_mult) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else if (dbz) begin
                        hi <= raw_a;
                        lo <= '1;
                    end else begin
                        hi <= rem;
                        lo <= quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oBusy      = (state != IDLE);
    assign bus.oDone      = (state == DONE);
    assign bus.oDivByZero = (state == DONE) && dbz;
    assign bus.oHI        = hi;
    assign bus.oLO        = lo;
endmodule
